// File: rtl/candy_if_pkg.sv
// candy_if_pkg: shared constants for the candy fetch stage.
//   CANDY_ADDR_W      default instruction address width (word addressed)
//   CANDY_INST_W      default instruction width (typecode in [23:22])
//   CANDY_FETCH_DEPTH default prefetch FIFO depth / outstanding-request limit
//   RST_ENABLE        asserted level of the active-low reset
package candy_if_pkg;

  localparam int unsigned CANDY_ADDR_W      = 16;
  localparam int unsigned CANDY_INST_W      = 24;
  localparam int unsigned CANDY_FETCH_DEPTH = 2;
  localparam logic        RST_ENABLE        = 1'b0;

endpackage

// File: rtl/candy_if_fifo.sv
// candy_if_fifo: DEPTH-entry synchronous FIFO holding {pc, inst} pairs.
//   clk, rst    clock, asynchronous active-low reset
//   push, wdata write one entry (never while full without a pop)
//   pop, rdata  rdata is the head entry, valid while !empty; pop removes it
//   flush       discard all entries (wins over push/pop)
//   full, empty occupancy flags
//   count       number of stored entries
module candy_if_fifo
  import candy_if_pkg::*;
#(
  parameter int unsigned W     = 40,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The fetch credit limit keeps pushes away from a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
                                  !(push && !flush && full && !pop));

endmodule

// File: rtl/candy_if.sv
// candy_if: instruction-fetch stage feeding decode.
//   clk, rst            clock, asynchronous active-low reset
//   stall               hold inst/id_enable/pc_out
//   redirect,redirect_pc load a new PC, flush buffered and in-flight fetches
//   imem_req/addr/gnt   in-order read request handshake (req & gnt)
//   imem_rvalid/rdata   in-order read responses, >=1 cycle after gnt
//   inst, id_enable     registered instruction and its valid flag
//   pc_out              address of the instruction on inst
module candy_if
  import candy_if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = CANDY_ADDR_W,
  parameter int unsigned       INST_W   = CANDY_INST_W,
  parameter int unsigned       DEPTH    = CANDY_FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              id_enable,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = ADDR_W + INST_W;
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ret_pc;      // PC belonging to the next kept response
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     kill;        // responses still to be discarded after a redirect
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [EW-1:0]     fifo_rdata;
  logic [CW:0]       in_use;
  logic              rsp_valid;
  logic              rsp_keep;
  logic              bypass;
  logic              fire;

  always_comb begin
    in_use    = {1'b0, fifo_count} + {1'b0, outstanding};
    imem_req  = (rst != RST_ENABLE) && !redirect && (in_use < CAP);
    imem_addr = pc;
    fire      = imem_req && imem_gnt;
    // A response with nothing outstanding is a stale one from before reset.
    rsp_valid = imem_rvalid && (outstanding != '0);
    rsp_keep  = rsp_valid && (kill == '0) && !redirect;
    // Returning data goes straight to the output register when nothing
    // is queued ahead of it, otherwise it waits in the FIFO.
    bypass    = rsp_keep && !stall && fifo_empty;
    fifo_push = rsp_keep && !bypass;
    fifo_pop  = !redirect && !stall && !fifo_empty;
  end

  candy_if_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({ret_pc, imem_rdata}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .flush (redirect),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      pc          <= RESET_PC;
      ret_pc      <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      inst        <= '0;
      id_enable   <= 1'b0;
      pc_out      <= '0;
    end else if (redirect) begin
      // Every request still in flight is older than the redirect target.
      pc          <= redirect_pc;
      ret_pc      <= redirect_pc;
      outstanding <= outstanding - CW'(rsp_valid);
      kill        <= outstanding - CW'(rsp_valid);
      id_enable   <= 1'b0;
    end else begin
      if (fire) begin
        pc <= pc + 1'b1;
      end
      case ({fire, rsp_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (rsp_valid && (kill != '0)) begin
        kill <= kill - 1'b1;
      end
      if (rsp_keep) begin
        ret_pc <= ret_pc + 1'b1;
      end
      if (!stall) begin
        if (!fifo_empty) begin
          {pc_out, inst} <= fifo_rdata;
          id_enable      <= 1'b1;
        end else if (bypass) begin
          pc_out    <= ret_pc;
          inst      <= imem_rdata;
          id_enable <= 1'b1;
        end else begin
          id_enable <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_candy_if.sv
module tb_candy_if;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned INST_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic [INST_W-1:0] inst;
  logic              id_enable;
  logic [ADDR_W-1:0] pc_out;

  int n_checks = 0;
  int n_fail   = 0;

  // imem model: responses return in order, the cycle after the grant
  logic              hold_rsp;
  logic [ADDR_W-1:0] pend_q[$];
  logic [ADDR_W-1:0] rsp_addr;

  always #5 clk = ~clk;

  candy_if #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .id_enable   (id_enable),
    .pc_out      (pc_out)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q.delete();
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      if (imem_req && imem_gnt) pend_q.push_back(imem_addr);
      if (!hold_rsp && pend_q.size() != 0) begin
        rsp_addr = pend_q.pop_front();
        imem_rvalid <= 1'b1;
        imem_rdata  <= 24'h400000 + {8'h00, rsp_addr};
      end else begin
        imem_rvalid <= 1'b0;
      end
    end
  end

  // Reset for two cycles, release on a falling edge.
  task automatic apply_reset(input logic gnt);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    hold_rsp = 1'b0; imem_gnt = gnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    hold_rsp = 1'b0; imem_gnt = 1'b1;
    #1;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++;
    if ({id_enable, pc_out, inst} !== 41'h0) begin
      n_fail++; $display("FAIL reset_outputs: got id=%b pc=%h inst=%h expected all zero", id_enable, pc_out, inst);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequence();
    logic [40:0] exp;
    apply_reset(1'b1);
    @(negedge clk);
    n_checks++;
    if (id_enable !== 1'b0) begin n_fail++; $display("FAIL seq_first_idle: got id=%b expected 0", id_enable); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp = {1'b1, 16'(k), 24'h400000 + 24'(k)};
      n_checks++;
      if ({id_enable, pc_out, inst} !== exp) begin
        n_fail++; $display("FAIL seq[%0d]: got %h expected %h", k, {id_enable, pc_out, inst}, exp);
      end
    end
  endtask

  task automatic test_gnt_wait();
    apply_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({imem_req, imem_addr, id_enable} !== {1'b1, 16'h0000, 1'b0}) begin
        n_fail++; $display("FAIL gnt_wait[%0d]: got req=%b addr=%h id=%b expected req=1 addr=0000 id=0",
                           k, imem_req, imem_addr, id_enable);
      end
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (id_enable !== 1'b0) begin n_fail++; $display("FAIL gnt_wait_lat1: got id=%b expected 0", id_enable); end
    @(negedge clk);
    n_checks++;
    if ({id_enable, pc_out, inst} !== {1'b1, 16'h0000, 24'h400000}) begin
      n_fail++; $display("FAIL gnt_wait_first: got %h expected %h", {id_enable, pc_out, inst}, {1'b1, 16'h0000, 24'h400000});
    end
  endtask

  task automatic test_stall();
    logic [40:0] exp;
    apply_reset(1'b1);
    @(negedge clk);
    @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({imem_req, id_enable, pc_out, inst} !== {1'b0, 1'b1, 16'h0000, 24'h400000}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got req=%b %h expected req=0 %h", k, imem_req,
                           {id_enable, pc_out, inst}, {1'b1, 16'h0000, 24'h400000});
      end
    end
    stall = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      exp = {1'b1, 16'(k), 24'h400000 + 24'(k)};
      n_checks++;
      if ({id_enable, pc_out, inst} !== exp) begin
        n_fail++; $display("FAIL stall_resume[%0d]: got %h expected %h", k, {id_enable, pc_out, inst}, exp);
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset(1'b1);
    hold_rsp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0100; hold_rsp = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redirect_req: got %b expected 0", imem_req); end
    @(negedge clk);
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (id_enable !== 1'b0) begin n_fail++; $display("FAIL redirect_drop[%0d]: got id=%b pc=%h expected id=0", k, id_enable, pc_out); end
      @(negedge clk);
    end
    n_checks++;
    if ({id_enable, pc_out, inst} !== {1'b1, 16'h0100, 24'h400100}) begin
      n_fail++; $display("FAIL redirect_target: got %h expected %h", {id_enable, pc_out, inst}, {1'b1, 16'h0100, 24'h400100});
    end
    @(negedge clk);
    n_checks++;
    if ({id_enable, pc_out, inst} !== {1'b1, 16'h0101, 24'h400101}) begin
      n_fail++; $display("FAIL redirect_next: got %h expected %h", {id_enable, pc_out, inst}, {1'b1, 16'h0101, 24'h400101});
    end
  endtask

  task automatic test_wrap();
    apply_reset(1'b1);
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'hFFFF}) begin
      n_fail++; $display("FAIL wrap_addr_ffff: got req=%b addr=%h expected req=1 addr=ffff", imem_req, imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL wrap_addr_0000: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({id_enable, pc_out, inst} !== {1'b1, 16'hFFFF, 24'h40FFFF}) begin
      n_fail++; $display("FAIL wrap_pc_ffff: got %h expected %h", {id_enable, pc_out, inst}, {1'b1, 16'hFFFF, 24'h40FFFF});
    end
    @(negedge clk);
    n_checks++;
    if ({id_enable, pc_out, inst} !== {1'b1, 16'h0000, 24'h400000}) begin
      n_fail++; $display("FAIL wrap_pc_0000: got %h expected %h", {id_enable, pc_out, inst}, {1'b1, 16'h0000, 24'h400000});
    end
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset(1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    hold_rsp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({imem_req, id_enable, pc_out, inst} !== {1'b0, 1'b0, 16'h0002, 24'h400002}) begin
      n_fail++; $display("FAIL midrst_before: got req=%b %h expected req=0 %h", imem_req,
                         {id_enable, pc_out, inst}, {1'b0, 16'h0002, 24'h400002});
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, id_enable, pc_out, inst} !== 42'h0) begin
      n_fail++; $display("FAIL midrst_async: got req=%b id=%b pc=%h inst=%h expected all zero",
                         imem_req, id_enable, pc_out, inst);
    end
    @(negedge clk);
    hold_rsp = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL midrst_restart_req: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({id_enable, pc_out, inst} !== {1'b1, 16'h0000, 24'h400000}) begin
      n_fail++; $display("FAIL midrst_restart_inst: got %h expected %h", {id_enable, pc_out, inst}, {1'b1, 16'h0000, 24'h400000});
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_gnt_wait();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
